// File: rtl/gcd_lcm_stage.sv
`default_nettype none
// ============================================================================
// Module      : gcd_lcm_stage
// Description : Computes lcm = (a / g) * b from an operand set {a, b, g}
//               delivered by an upstream GCD engine. A restoring divider
//               (one quotient bit per edge) is followed by a shift-add
//               multiplier (one multiplier bit per edge). One operation is in
//               flight at a time; valid/ready handshakes on both sides.
// Options     : LCM_SATURATE_EN - when defined, an overflowing product
//               returns lcm = all ones instead of the truncated low bits.
// Revision    : 1.0 - initial release
// ============================================================================
module gcd_lcm_stage #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] g,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] lcm,
   output logic             ovf,
   output logic             err
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DIV  = 2'd1,
      S_MUL  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     div_q, div_d;       // dividend in, quotient out
   logic [WIDTH-1:0]     rem_q, rem_d;       // partial remainder
   logic [WIDTH-1:0]     b_q, b_d;
   logic [WIDTH-1:0]     g_q, g_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;       // {product high, multiplier/product low}
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [WIDTH-1:0]     lcm_q, lcm_d;
   logic                 ovf_q, ovf_d;
   logic                 err_q, err_d;
   logic                 out_valid_q, out_valid_d;

   // Datapath helpers for one division step and one multiply step
   logic [WIDTH:0]       rem_shift;
   logic                 rem_ge;
   logic [WIDTH-1:0]     rem_next;
   logic [WIDTH:0]       mul_sum;
   logic [2*WIDTH-1:0]   mul_next;
   logic                 mul_ovf;
   logic [WIDTH-1:0]     mul_lcm;

   // Bring down the next dividend bit and trial-subtract the divisor.
   // When the trial succeeds the difference is below g, so the low WIDTH
   // bits of the subtraction are exact.
   assign rem_shift = {rem_q, div_q[WIDTH-1]};
   assign rem_ge    = (rem_shift >= {1'b0, g_q});
   assign rem_next  = rem_ge ? (rem_shift[WIDTH-1:0] - g_q) : rem_shift[WIDTH-1:0];

   // Add b into the high half when the current multiplier bit is set, then
   // shift the whole accumulator right (carry enters at the top).
   assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? b_q : {WIDTH{1'b0}})};
   assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};
   assign mul_ovf  = |mul_next[2*WIDTH-1:WIDTH];

`ifdef LCM_SATURATE_EN
   assign mul_lcm = mul_ovf ? {WIDTH{1'b1}} : mul_next[WIDTH-1:0];
`else
   assign mul_lcm = mul_next[WIDTH-1:0];
`endif

   // Next-state and next-datapath decode for the IDLE/DIV/MUL/DONE sequence
   always_comb begin
      state_d     = state_q;
      div_d       = div_q;
      rem_d       = rem_q;
      b_d         = b_q;
      g_d         = g_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      lcm_d       = lcm_q;
      ovf_d       = ovf_q;
      err_d       = err_q;
      out_valid_d = out_valid_q;

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               div_d = a;
               b_d   = b;
               g_d   = g;
               rem_d = '0;
               acc_d = '0;
               cnt_d = '0;
               lcm_d = '0;
               ovf_d = 1'b0;
               err_d = 1'b0;
               if ((a == '0) || (b == '0)) begin
                  state_d     = S_DONE;
                  out_valid_d = 1'b1;
               end else if (g == '0) begin
                  err_d       = 1'b1;
                  state_d     = S_DONE;
                  out_valid_d = 1'b1;
               end else begin
                  state_d = S_DIV;
               end
            end
         end

         S_DIV: begin
            div_d = {div_q[WIDTH-2:0], rem_ge};
            rem_d = rem_next;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) begin
               // Quotient becomes the multiplier in the low accumulator half
               acc_d   = {{WIDTH{1'b0}}, div_q[WIDTH-2:0], rem_ge};
               cnt_d   = '0;
               state_d = S_MUL;
            end
         end

         S_MUL: begin
            acc_d = mul_next;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) begin
               cnt_d       = '0;
               lcm_d       = mul_lcm;
               ovf_d       = mul_ovf;
               out_valid_d = 1'b1;
               state_d     = S_DONE;
            end
         end

         S_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end

         default: begin
            out_valid_d = 1'b0;
            state_d     = S_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         div_q       <= '0;
         rem_q       <= '0;
         b_q         <= '0;
         g_q         <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         lcm_q       <= '0;
         ovf_q       <= 1'b0;
         err_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         div_q       <= div_d;
         rem_q       <= rem_d;
         b_q         <= b_d;
         g_q         <= g_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         lcm_q       <= lcm_d;
         ovf_q       <= ovf_d;
         err_q       <= err_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = out_valid_q;
   assign lcm       = lcm_q;
   assign ovf       = ovf_q;
   assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_gcd_lcm_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_gcd_lcm_stage
// Description : Self-checking bench for gcd_lcm_stage (WIDTH = 32). Vector
//               table for the main function plus hand sequences for output
//               backpressure and reset abort. Honours LCM_SATURATE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gcd_lcm_stage;

   localparam int W   = 32;
   localparam int LAT = 2 * W;   // edges from accept to visible out_valid

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a_i, b_i, g_i;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] lcm;
   logic         ovf;
   logic         err;

   gcd_lcm_stage #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a_i),
      .b         (b_i),
      .g         (g_i),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .lcm       (lcm),
      .ovf       (ovf),
      .err       (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] g;
      logic [W-1:0] lcm;   // truncated low bits of the true product
      logic         ovf;
      logic         err;
      int           lat;
   } vec_t;

   typedef struct {
      logic [W-1:0] lcm;
      logic         ovf;
      logic         err;
   } res_t;

   int   checks = 0;
   int   errors = 0;
   res_t exp_q[$];
   vec_t vecs[11];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic logic [W-1:0] model_lcm(input logic [W-1:0] low, input logic o);
`ifdef LCM_SATURATE_EN
      return o ? {W{1'b1}} : low;
`else
      return low;
`endif
   endfunction

   // Drive one operand set through the accept edge; optionally record the
   // expected result on the scoreboard. Returns #1 after the accept edge.
   task automatic do_accept(input logic [W-1:0] av, input logic [W-1:0] bv,
                            input logic [W-1:0] gv, input logic [W-1:0] el,
                            input logic eo, input logic ee, input bit push);
      res_t r;
      @(negedge clk);
      a_i      = av;
      b_i      = bv;
      g_i      = gv;
      in_valid = 1'b1;
      chk("in_ready_before_accept", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a_i      = $urandom;
      b_i      = $urandom;
      g_i      = $urandom;
      if (push) begin
         r.lcm = model_lcm(el, eo);
         r.ovf = eo;
         r.err = ee;
         exp_q.push_back(r);
      end
   endtask

   // Wait (bounded) for out_valid, check latency, then pop and compare.
   task automatic await_result(input int exp_lat);
      int   lat;
      res_t r;
      lat = 0;
      chk("in_ready_after_accept", 64'(in_ready), 64'd0);
      while (!out_valid && lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk("latency", 64'(lat), 64'(exp_lat));
      if (!out_valid) begin
         errors++;
         $display("FAIL out_valid_timeout actual=0 required=1");
         if (exp_q.size() > 0) void'(exp_q.pop_front());
      end else if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL scoreboard_empty actual=0 required=1");
      end else begin
         r = exp_q.pop_front();
         chk("lcm", 64'(lcm), 64'(r.lcm));
         chk("ovf", 64'(ovf), 64'(r.ovf));
         chk("err", 64'(err), 64'(r.err));
      end
   endtask

   // Complete the output handshake with out_ready already high.
   task automatic handshake();
      @(posedge clk);
      #1;
      chk("out_valid_after_hs", 64'(out_valid), 64'd0);
      chk("in_ready_after_hs", 64'(in_ready), 64'd1);
   endtask

   initial begin
      bit seen;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a_i       = '0;
      b_i       = '0;
      g_i       = '0;

      vecs[0]  = '{32'd12,        32'd18,        32'd6,         32'd36,        1'b0, 1'b0, LAT};
      vecs[1]  = '{32'd0,         32'd7,         32'd7,         32'd0,         1'b0, 1'b0, 0};
      vecs[2]  = '{32'd5,         32'd9,         32'd0,         32'd0,         1'b0, 1'b1, 0};
      vecs[3]  = '{32'h8000_0000, 32'd3,         32'd1,         32'h8000_0000, 1'b1, 1'b0, LAT};
      vecs[4]  = '{32'd21,        32'd6,         32'd3,         32'd42,        1'b0, 1'b0, LAT};
      vecs[5]  = '{32'd7,         32'd0,         32'd0,         32'd0,         1'b0, 1'b0, 0};
      vecs[6]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, LAT};
      vecs[7]  = '{32'h0001_0000, 32'h0001_0000, 32'd1,         32'd0,         1'b1, 1'b0, LAT};
      vecs[8]  = '{32'd10,        32'd4,         32'd3,         32'd12,        1'b0, 1'b0, LAT};
      vecs[9]  = '{32'd1,         32'd1,         32'd1,         32'd1,         1'b0, 1'b0, LAT};
      vecs[10] = '{32'hFFFF_FFFF, 32'd2,         32'd1,         32'hFFFF_FFFE, 1'b1, 1'b0, LAT};

      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_lcm", 64'(lcm), 64'd0);
      chk("rst_ovf", 64'(ovf), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_in_ready", 64'(in_ready), 64'd1);

      for (int i = 0; i < 11; i++) begin
         do_accept(vecs[i].a, vecs[i].b, vecs[i].g, vecs[i].lcm, vecs[i].ovf, vecs[i].err, 1'b1);
         await_result(vecs[i].lat);
         handshake();
      end

      // Backpressure: result held stable, in_valid pulses ignored
      out_ready = 1'b0;
      do_accept(32'd21, 32'd6, 32'd3, 32'd42, 1'b0, 1'b0, 1'b1);
      await_result(LAT);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         in_valid = k[0];
         a_i      = 32'd100 + 32'(k);
         b_i      = 32'd7;
         g_i      = 32'd1;
         @(posedge clk);
         #1;
         chk("hold_out_valid", 64'(out_valid), 64'd1);
         chk("hold_lcm", 64'(lcm), 64'd42);
         chk("hold_in_ready", 64'(in_ready), 64'd0);
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      handshake();
      repeat (3) @(posedge clk);
      #1;
      chk("no_spurious_result", 64'(out_valid), 64'd0);

      // Reset in the middle of the division aborts the operation
      do_accept(32'd12, 32'd18, 32'd6, 32'd0, 1'b0, 1'b0, 1'b0);
      repeat (10) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("abort_out_valid", 64'(out_valid), 64'd0);
      chk("abort_lcm", 64'(lcm), 64'd0);
      chk("abort_ovf", 64'(ovf), 64'd0);
      chk("abort_err", 64'(err), 64'd0);
      chk("abort_in_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
      rst  = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 70; k++) begin
         @(posedge clk);
         #1;
         if (out_valid) seen = 1'b1;
      end
      chk("abort_no_result", 64'(seen), 64'd0);
      do_accept(32'd4, 32'd6, 32'd2, 32'd12, 1'b0, 1'b0, 1'b1);
      await_result(LAT);
      handshake();

      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/gcd_lcm_stage.md
Name: gcd_lcm_stage

Overview:
- Downstream consumer of the GCD engine: takes operands a, b plus their GCD g and computes lcm = (a / g) * b.
- Uses a sequential restoring divider followed by a shift-add multiplier; no combinational divide or multiply.
- valid/ready handshake on input and output, so it can sit behind the GCD block and ahead of any result sink.
- One operation in flight at a time.

Parameters:
- WIDTH, 32, bit width of a, b, g and lcm.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand set {a,b,g} valid
- in_ready  output  1  stage idle, can accept operands
- a  input  WIDTH  first operand
- b  input  WIDTH  second operand
- g  input  WIDTH  gcd(a,b) from upstream GCD stage
- out_valid  output  1  lcm/ovf/err valid
- out_ready  input  1  sink accepts result
- lcm  output  WIDTH  least common multiple (low WIDTH bits, or saturated, see Optional Feature)
- ovf  output  1  true product exceeded WIDTH bits
- err  output  1  g==0 with a,b nonzero (invalid GCD)

Behaviour:
- Reset: clk, rst as stated (synchronous, active-high). Reset forces state IDLE, out_valid=0, lcm=0, ovf=0, err=0 and clears all internal registers. in_ready=1 in the cycle after reset.
- in_ready = (state==IDLE), decoded from registered state only. Operands are accepted on an edge with in_valid & in_ready; a, b and g are captured into internal registers on that edge.
- States:
  - IDLE: wait for accept.
    - On accept with a==0 or b==0: go to DONE with lcm=0, ovf=0, err=0.
    - On accept with g==0 and a,b nonzero: go to DONE with lcm=0, err=1.
    - Otherwise go to DIV.
  - DIV: restoring division q = a / g, one quotient bit per edge, MSB first, exactly WIDTH edges, then MUL. The remainder is discarded; a non-multiple a is not flagged.
  - MUL: shift-add q*b into a 2*WIDTH accumulator, one multiplier bit per edge, exactly WIDTH edges, then DONE.
    - ovf = |product[2*WIDTH-1:WIDTH]
    - lcm = product[WIDTH-1:0]
  - DONE: out_valid=1. lcm, ovf and err are held stable while out_ready=0. On out_valid & out_ready go to IDLE and drop out_valid on that edge.
- Latency:
  - Normal path: out_valid visible 2*WIDTH+1 cycles after the accept edge (65 for WIDTH=32), i.e. after 2*WIDTH further edges.
  - Bypass path (zero or err): out_valid visible in the cycle right after accept.
- No accept while in DIV, MUL or DONE. A new operand set can be accepted at the earliest on the edge after the output handshake.
- Input changes on a/b/g after the accept edge have no effect.
- rst asserted in any state, including mid-DIV or mid-MUL, aborts the operation; the result is lost and no out_valid is produced.
- Unused state encodings return to IDLE on the next edge.

Optional Feature:
- Macro LCM_SATURATE_EN.
- Defined: when ovf=1, lcm is forced to all ones (2^WIDTH-1) in DONE; ovf still reports 1.
- Undefined: lcm is the truncated low WIDTH bits of the product.
- err and zero cases are unaffected either way.

Test Plan:
- a=12, b=18, g=6, out_ready=1 -> in_ready drops the cycle after accept; out_valid visible 65 cycles after the accept edge; lcm=36, ovf=0, err=0; in_ready=1 the cycle after the output handshake.
- a=0, b=7, g=7 -> out_valid visible in the cycle right after accept; lcm=0, ovf=0, err=0.
- a=5, b=9, g=0 -> out_valid visible in the cycle right after accept; lcm=0, err=1.
- a=0x80000000, b=3, g=1 -> ovf=1.
  - Macro undefined: lcm=0x80000000.
  - LCM_SATURATE_EN defined: lcm=0xFFFFFFFF.
- a=21, b=6, g=3, out_ready held 0 for 10 cycles after out_valid -> lcm=42 stable, out_valid held, in_valid pulses ignored; releasing out_ready completes the handshake.
- Accept a=12, b=18, g=6, then assert rst for 1 cycle during DIV -> out_valid never rises, outputs at reset values, in_ready=1 next cycle. A fresh a=4, b=6, g=2 then yields lcm=12.
